// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion (128/192/256-bit keys), one word per clock, with a registered round-key read port.
// Optional build macro AES_KS_REVERSE_READ_EN mirrors the read index (rk_idx=0 returns the final round key).
module aes_key_schedule #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out
);

    localparam int unsigned NK          = KEY_BITS / 32;
    localparam int unsigned NR          = NK + 6;
    localparam int unsigned TOTAL_WORDS = 4 * (NR + 1);
    localparam int unsigned IW          = 6;
    localparam int unsigned SW          = 3;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load_key;
    logic            write_word;

    logic [31:0]     w [TOTAL_WORDS];
    logic [IW-1:0]   word_cnt;
    logic [SW-1:0]   sub_cnt;
    logic [7:0]      rcon;

    logic [31:0]     prev_word;
    logic [31:0]     old_word;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     temp_word;
    logic [31:0]     new_word;

    logic            rd_ok;
    logic [3:0]      rd_round;
    logic [IW-1:0]   rd_base;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt  = state;
        load_key   = 1'b0;
        write_word = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_key  = 1'b1;
                    state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                write_word = 1'b1;
                if (word_cnt == IW'(TOTAL_WORDS - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word generator; the single S-box sees RotWord(t) on sub_cnt==0, plain t otherwise
    always_comb begin
        prev_word = w[word_cnt - IW'(1)];
        old_word  = w[word_cnt - IW'(NK)];
        sub_in    = (sub_cnt == '0) ? {prev_word[7:0], prev_word[31:8]} : prev_word;
        sub_out   = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                     SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
        temp_word = prev_word;
        if (sub_cnt == '0) begin
            temp_word = sub_out ^ {24'h0, rcon};
        end else if (NK == 8 && sub_cnt == SW'(4)) begin
            temp_word = sub_out;
        end
        new_word = old_word ^ temp_word;
    end

    // Round-key storage; intentionally not reset
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int j = 0; j < int'(NK); j++) begin
                w[j] <= key_in[32*j +: 32];
            end
        end else if (write_word) begin
            w[word_cnt] <= new_word;
        end
    end

    // Read index mapping; out-of-range indices are forced to zero output
    always_comb begin
        rd_ok = (rk_idx <= 4'(NR));
`ifdef AES_KS_REVERSE_READ_EN
        rd_round = 4'(NR) - rk_idx;
`else
        rd_round = rk_idx;
`endif
        rd_base = rd_ok ? {rd_round, 2'b00} : '0;
    end

    // Counters, status outputs and read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk_out     <= '0;
            word_cnt   <= IW'(NK);
            sub_cnt    <= '0;
            rcon       <= 8'h01;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
            if (load_key) begin
                keys_valid <= 1'b0;
            end else if (state_nxt == ST_DONE) begin
                keys_valid <= 1'b1;
            end

            if (load_key) begin
                word_cnt <= IW'(NK);
                sub_cnt  <= '0;
                rcon     <= 8'h01;
            end else if (write_word) begin
                word_cnt <= word_cnt + IW'(1);
                sub_cnt  <= (sub_cnt == SW'(NK - 1)) ? '0 : sub_cnt + SW'(1);
                if (sub_cnt == '0) begin
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
            end

            rk_out <= rd_ok ? {w[rd_base + IW'(3)], w[rd_base + IW'(2)],
                               w[rd_base + IW'(1)], w[rd_base]} : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: 128/192/256-bit instances against a GF(2^8)-derived key-expansion model.
module tb_aes_key_schedule;

    localparam logic [255:0] KEY128 = 256'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [255:0] KEY192 = 256'h17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [255:0] KEY256 = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] RK128_1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] RK128_10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
    localparam logic [127:0] RK192_12 = 128'h5d1da4e3_71c218c4_09dc781a_330a97a4;
    localparam logic [127:0] RK256_14 = 128'h36de686d_3cc21a37_e97909bf_cc79fc24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rk_idx;
    logic         start_v  [3];
    logic [255:0] key_bus  [3];
    logic         busy_v   [3];
    logic         done_v   [3];
    logic         kv_v     [3];
    logic [127:0] rk_out_v [3];

    logic [7:0]   sbox_t [256];
    logic [31:0]  mw [60];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key_bus[0][127:0]),
        .busy(busy_v[0]), .done(done_v[0]), .keys_valid(kv_v[0]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[0]));

    aes_key_schedule #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key_bus[1][191:0]),
        .busy(busy_v[1]), .done(done_v[1]), .keys_valid(kv_v[1]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[1]));

    aes_key_schedule #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key_bus[2]),
        .busy(busy_v[2]), .done(done_v[2]), .keys_valid(kv_v[2]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[2]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? (8'({a[6:0], 1'b0}) ^ 8'h1b) : 8'({a[6:0], 1'b0});
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int n = 0; n < 254; n++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    task automatic expand_model(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int j = 0; j < nk; j++) mw[j] = key[32*j +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int q = 1; q < i / nk; q++) rc = gmul(rc, 8'h02);
                t = subword({t[7:0], t[31:8]}) ^ {24'h0, rc};
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // Physical read index that returns logical round r in this build
    function automatic int phys(input int nr, input int r);
`ifdef AES_KS_REVERSE_READ_EN
        return nr - r;
`else
        return r;
`endif
    endfunction

    function automatic logic [127:0] model_rk(input int nr, input int idx);
        int r;
        if (idx > nr) return 128'h0;
        r = phys(nr, idx);
        return {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]};
    endfunction

    task automatic read_round(input int k, input int idx, input logic [127:0] exp, input string tag);
        rk_idx = 4'(idx);
        @(negedge clk);
        check_eq(tag, rk_out_v[k], exp);
    endtask

    task automatic run_expand(input int k, input logic [255:0] key, input bit spam);
        int nk = 4 + 2 * k;
        int nr = nk + 6;
        int cnt;
        bit seen;
        key_bus[k] = key;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        cnt = 1;
        check_eq("busy_after_start", 128'(busy_v[k]), 128'd1);
        check_eq("kv_drop_on_start", 128'(kv_v[k]), 128'd0);
        seen = done_v[k];
        while (!seen && cnt < 100) begin
            if (spam) start_v[k] = (cnt % 3 == 0);
            @(negedge clk);
            cnt++;
            seen = done_v[k];
        end
        start_v[k] = spam;
        check_eq("done_latency", 128'(cnt), 128'(4 * (nr + 1) - nk + 1));
        check_eq("kv_at_done", 128'(kv_v[k]), 128'd1);
        @(negedge clk);
        start_v[k] = 1'b0;
        check_eq("done_pulse_width", 128'(done_v[k]), 128'd0);
        check_eq("idle_after_done", 128'(busy_v[k]), 128'd0);
        check_eq("kv_held_idle", 128'(kv_v[k]), 128'd1);
        expand_model(key, nk);
        for (int idx = 0; idx < 16; idx++) read_round(k, idx, model_rk(nr, idx), "round_key");
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int  cnt;
        bit  any_done;
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
        rst_n = 1'b0;
        rk_idx = 4'd0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            key_bus[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("reset_busy", 128'(busy_v[k]), 128'd0);
            check_eq("reset_done", 128'(done_v[k]), 128'd0);
            check_eq("reset_kv", 128'(kv_v[k]), 128'd0);
            check_eq("reset_rk_out", rk_out_v[k], 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors
        run_expand(0, KEY128, 1'b0);
        read_round(0, phys(10, 1), RK128_1, "kat128_r1");
        read_round(0, phys(10, 10), RK128_10, "kat128_r10");
        read_round(0, phys(10, 0), KEY128[127:0], "kat128_r0");
        read_round(0, 11, 128'h0, "oor128_11");
        read_round(0, 15, 128'h0, "oor128_15");
        run_expand(1, KEY192, 1'b0);
        read_round(1, phys(12, 12), RK192_12, "kat192_r12");
        read_round(1, 13, 128'h0, "oor192_13");
        run_expand(2, KEY256, 1'b0);
        read_round(2, phys(14, 14), RK256_14, "kat256_r14");
        read_round(2, 15, 128'h0, "oor256_15");

        // start hammered during EXPAND and in the DONE cycle
        run_expand(0, KEY128, 1'b1);
        read_round(0, phys(10, 10), RK128_10, "spam_r10");

        // Synchronous reset in the middle of an expansion
        key_bus[0] = rand_key();
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_busy", 128'(busy_v[0]), 128'd0);
        check_eq("midrst_kv", 128'(kv_v[0]), 128'd0);
        any_done = 1'b0;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (done_v[0] || kv_v[0]) any_done = 1'b1;
        end
        check_eq("midrst_no_done", 128'(any_done), 128'd0);
        run_expand(0, KEY128, 1'b0);
        read_round(0, phys(10, 10), RK128_10, "after_rst_r10");

        // Random keys for every size
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 3; k++) run_expand(k, rand_key(), n == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
